// File: rtl/status_req_arbiter_pkg.sv
// Shared geometry and state encoding for the status array front-end.
package status_req_arbiter_pkg;

    localparam int NUM_ROWS    = 16;
    localparam int ADDR_WIDTH  = 4;
    localparam int NUM_BLOCKS  = 4;
    localparam int BLOCK_WIDTH = 2;
    localparam int ROW_WIDTH   = NUM_BLOCKS * BLOCK_WIDTH;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic                  wen;
        logic [ADDR_WIDTH-1:0] addr;
        logic [ROW_WIDTH-1:0]  data;
        logic [NUM_BLOCKS-1:0] wmask;
    } arr_req_t;

    localparam arr_req_t REQ_IDLE = '0;

endpackage

// File: rtl/row_sweeper.sv
// Row counter and INIT/RUN state bit for the zeroing sweep.
module row_sweeper
    import status_req_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_en,
    input  logic                  i_clr,
    output logic [ADDR_WIDTH-1:0] o_row,
    output logic                  o_last,
    output state_e                o_state
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    assign o_row   = cnt_q;
    assign o_state = state_q;
    assign o_last  = (cnt_q == ADDR_WIDTH'(NUM_ROWS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (i_en) begin
            if (i_clr) begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end else if (state_q == ST_INIT) begin
                // Wraps to 0 on the last row, ready for the next flush.
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (o_last) begin
                    state_d = ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/status_req_arbiter.sv
// Zeroing sweep plus update/lookup merge in front of the status array.
module status_req_arbiter
    import status_req_arbiter_pkg::*;
#(
    parameter int TAG_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_sa_ready,
    input  logic                  i_flush,
    input  logic                  i_lk_valid,
    input  logic [ADDR_WIDTH-1:0] i_lk_addr,
    input  logic [TAG_WIDTH-1:0]  i_lk_tag,
    output logic                  o_lk_ready,
    input  logic                  i_upd_valid,
    input  logic [ADDR_WIDTH-1:0] i_upd_addr,
    input  logic [ROW_WIDTH-1:0]  i_upd_data,
    input  logic [NUM_BLOCKS-1:0] i_upd_wmask,
    output logic                  o_upd_ready,
    output logic [TAG_WIDTH-1:0]  o_tag,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ROW_WIDTH-1:0]  o_data,
    output logic                  o_wen,
    output logic [NUM_BLOCKS-1:0] o_wmask,
    output logic                  o_valid,
    output logic                  o_init_done
);

    logic [ADDR_WIDTH-1:0] row;
    logic                  last;
    state_e                state;
    logic                  run;

    arr_req_t              req_q, req_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;

    row_sweeper u_sweeper (
        .clk     (clk),
        .arst_n  (arst_n),
        .i_en    (i_sa_ready),
        .i_clr   (i_flush),
        .o_row   (row),
        .o_last  (last),
        .o_state (state)
    );

    assign run         = (state == ST_RUN);
    assign o_upd_ready = run & i_sa_ready & ~i_flush;
    assign o_lk_ready  = o_upd_ready & ~i_upd_valid;

    always_comb begin
        req_d = req_q;
        tag_d = tag_q;
        if (i_sa_ready) begin
            req_d = REQ_IDLE;
            tag_d = '0;
            // A flush presents row 0 on the same edge it restarts the sweep.
            if (i_flush || !run) begin
                req_d.valid = 1'b1;
                req_d.wen   = 1'b1;
                req_d.addr  = i_flush ? '0 : row;
                req_d.wmask = '1;
            end else if (i_upd_valid) begin
                req_d.valid = 1'b1;
                req_d.wen   = 1'b1;
                req_d.addr  = i_upd_addr;
                req_d.data  = i_upd_data;
                req_d.wmask = i_upd_wmask;
            end else if (i_lk_valid) begin
                req_d.valid = 1'b1;
                req_d.addr  = i_lk_addr;
                tag_d       = i_lk_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            req_q <= REQ_IDLE;
            tag_q <= '0;
        end else begin
            req_q <= req_d;
            tag_q <= tag_d;
        end
    end

    assign o_tag       = tag_q;
    assign o_addr      = req_q.addr;
    assign o_data      = req_q.data;
    assign o_wen       = req_q.wen;
    assign o_wmask     = req_q.wmask;
    assign o_valid     = req_q.valid;
    assign o_init_done = run;

    logic unused_last;
    assign unused_last = last;

endmodule

// File: tb/tb_status_req_arbiter.sv
// Vector table plus scoreboard bench for status_req_arbiter.
module tb_status_req_arbiter;

    logic       clk;
    logic       arst_n;
    logic       sa, fl, lkv, lkt, upv;
    logic [3:0] lka, ua, um;
    logic [7:0] ud;
    logic       lkr, upr;
    logic       o_tag;
    logic [3:0] o_addr, o_wmask;
    logic [7:0] o_data;
    logic       o_wen, o_valid, o_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       sa, fl, lkv, lkt, upv;
        logic [3:0] lka, ua, um;
        logic [7:0] ud;
        logic       lkr, upr;
        logic [19:0] exp;
        string      nm;
    } vec_t;

    logic [19:0] sbq[$];
    vec_t        tbl[$];

    status_req_arbiter #(.TAG_WIDTH(1)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .i_sa_ready  (sa),
        .i_flush     (fl),
        .i_lk_valid  (lkv),
        .i_lk_addr   (lka),
        .i_lk_tag    (lkt),
        .o_lk_ready  (lkr),
        .i_upd_valid (upv),
        .i_upd_addr  (ua),
        .i_upd_data  (ud),
        .i_upd_wmask (um),
        .o_upd_ready (upr),
        .o_tag       (o_tag),
        .o_addr      (o_addr),
        .o_data      (o_data),
        .o_wen       (o_wen),
        .o_wmask     (o_wmask),
        .o_valid     (o_valid),
        .o_init_done (o_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    function automatic logic [19:0] eo(
        logic d, logic v, logic w, logic [3:0] m,
        logic [7:0] dt, logic [3:0] a, logic t);
        return {d, v, w, m, dt, a, t};
    endfunction

    function automatic logic [19:0] outv();
        return {o_done, o_valid, o_wen, o_wmask,
                o_data, o_addr, o_tag};
    endfunction

    function automatic vec_t mk(
        string nm, logic s, logic f,
        logic lv, logic [3:0] la, logic lt,
        logic uv, logic [3:0] a, logic [7:0] d,
        logic [3:0] m, logic elk, logic eup,
        logic [19:0] e);
        vec_t v;
        v.nm = nm; v.sa = s; v.fl = f;
        v.lkv = lv; v.lka = la; v.lkt = lt;
        v.upv = uv; v.ua = a; v.ud = d; v.um = m;
        v.lkr = elk; v.upr = eup; v.exp = e;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called at posedge+1: drive, check readies, clock, check outputs.
    task automatic apply(input vec_t v);
        logic [19:0] e;
        sa = v.sa; fl = v.fl;
        lkv = v.lkv; lka = v.lka; lkt = v.lkt;
        upv = v.upv; ua = v.ua; ud = v.ud; um = v.um;
        #1;
        chk({v.nm, "_rdy"}, {30'd0, lkr, upr},
            {30'd0, v.lkr, v.upr});
        sbq.push_back(v.exp);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk({v.nm, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            chk(v.nm, {12'd0, outv()}, {12'd0, e});
        end
    endtask

    function automatic logic [19:0] swp(int r);
        return eo(r == 15, 1, 1, 4'hF, 8'h00, 4'(r), 0);
    endfunction

    task automatic sweep(int lo, int hi, logic uv);
        for (int r = lo; r <= hi; r++) begin
            apply(mk($sformatf("sweep_r%0d", r), 1, 0,
                     1, 4'h7, 1, uv, 4'h2, 8'h3C, 4'h3,
                     0, 0, swp(r)));
        end
    endtask

    task automatic rst_release();
        sa = 0; fl = 0; lkv = 0; upv = 0;
        #2 arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst_n = 1'b1;
        sa = 0; fl = 0; lkv = 0; lka = 0; lkt = 0;
        upv = 0; ua = 0; ud = 0; um = 0;
        #2 arst_n = 1'b0;
        #1;
        chk("reset_out", {12'd0, outv()}, 32'd0);
        chk("reset_rdy", {30'd0, lkr, upr}, 32'd0);
        repeat (2) @(posedge clk);
        rst_release();

        sweep(0, 15, 1'b0);

        tbl.push_back(mk("lk7", 1, 0, 1, 4'h7, 1,
            0, 0, 0, 0, 1, 1, eo(1, 1, 0, 0, 0, 4'h7, 1)));
        tbl.push_back(mk("upd_wins", 1, 0, 1, 4'h3, 0,
            1, 4'h3, 8'hA5, 4'b0101, 0, 1,
            eo(1, 1, 1, 4'b0101, 8'hA5, 4'h3, 0)));
        tbl.push_back(mk("lk3_after", 1, 0, 1, 4'h3, 0,
            0, 0, 0, 0, 1, 1, eo(1, 1, 0, 0, 0, 4'h3, 0)));
        tbl.push_back(mk("idle", 1, 0, 0, 0, 0,
            0, 0, 0, 0, 1, 1, eo(1, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk("lk5", 1, 0, 1, 4'h5, 1,
            0, 0, 0, 0, 1, 1, eo(1, 1, 0, 0, 0, 4'h5, 1)));
        tbl.push_back(mk("halt1", 0, 0, 0, 0, 0,
            1, 4'h9, 8'h11, 4'h1, 0, 0,
            eo(1, 1, 0, 0, 0, 4'h5, 1)));
        tbl.push_back(mk("halt2", 0, 0, 1, 4'h1, 0,
            1, 4'h9, 8'h11, 4'h1, 0, 0,
            eo(1, 1, 0, 0, 0, 4'h5, 1)));
        tbl.push_back(mk("updF", 1, 0, 0, 0, 0,
            1, 4'hF, 8'hFF, 4'hF, 0, 1,
            eo(1, 1, 1, 4'hF, 8'hFF, 4'hF, 0)));
        tbl.push_back(mk("lk0", 1, 0, 1, 4'h0, 1,
            0, 0, 0, 0, 1, 1, eo(1, 1, 0, 0, 0, 4'h0, 1)));
        tbl.push_back(mk("flush_halt", 0, 1, 0, 0, 0,
            0, 0, 0, 0, 0, 0, eo(1, 1, 0, 0, 0, 4'h0, 1)));
        tbl.push_back(mk("idle2", 1, 0, 0, 0, 0,
            0, 0, 0, 0, 1, 1, eo(1, 0, 0, 0, 0, 0, 0)));
        foreach (tbl[i]) apply(tbl[i]);

        // Flush in RUN with a pending update, plus a halt at row 9.
        apply(mk("flush_run", 1, 1, 0, 0, 0,
            1, 4'h2, 8'h3C, 4'h3, 0, 0, swp(0) & ~20'h80000));
        sweep(0, 9, 1'b1);
        for (int h = 0; h < 5; h++) begin
            apply(mk($sformatf("halt_r9_%0d", h), 0, 0,
                1, 4'h7, 1, 1, 4'h2, 8'h3C, 4'h3,
                0, 0, swp(9)));
        end
        sweep(10, 15, 1'b1);
        apply(mk("upd_post_flush", 1, 0, 1, 4'h7, 1,
            1, 4'h2, 8'h3C, 4'h3, 0, 1,
            eo(1, 1, 1, 4'h3, 8'h3C, 4'h2, 0)));

        // Flush during INIT restarts from row 0.
        apply(mk("flush_run2", 1, 1, 0, 0, 0,
            0, 0, 0, 0, 0, 0, swp(0)));
        sweep(0, 5, 1'b0);
        apply(mk("flush_init", 1, 1, 0, 0, 0,
            0, 0, 0, 0, 0, 0, swp(0)));
        sweep(0, 12, 1'b0);

        // Asynchronous reset while row 12 is presented.
        arst_n = 1'b0;
        #1;
        chk("async_rst_out", {12'd0, outv()}, 32'd0);
        chk("async_rst_rdy", {30'd0, lkr, upr}, 32'd0);
        rst_release();
        sweep(0, 15, 1'b0);
        apply(mk("idle_end", 1, 0, 0, 0, 0,
            0, 0, 0, 0, 1, 1, eo(1, 0, 0, 0, 0, 0, 0)));

        chk("sb_drained", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
